// File: rtl/switch_port_tx.sv
//------------------------------------------------------------------------------
// Module      : switch_port_tx
// Description : Queued single-beat packet transmitter for one switch ingress
//               port, with inter-packet gap and port-full backpressure.
//               Optional statistics counters: define PORT_TX_STATS_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module switch_port_tx #(
   parameter int PORT_ID    = 0,
   parameter int DATA_WIDTH = 8,
   parameter int QDEPTH     = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_target,
   input  logic [DATA_WIDTH-1:0] req_data,
   input  logic                  port_full,
   output logic                  tx_valid,
   output logic [3:0]            tx_source,
   output logic [3:0]            tx_target,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  err_illegal,
   output logic                  busy,
   output logic [15:0]           tx_sent_cnt,
   output logic [15:0]           tx_rej_cnt
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int GAP_W = $clog2(GAP_CYCLES + 2);
   localparam int ENT_W = 4 + DATA_WIDTH;
   localparam logic [3:0] SELF_BIT = 4'(1 << PORT_ID);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   logic [ENT_W-1:0]      mem_q [QDEPTH];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic [1:0]            state_q;
   logic [1:0]            state_d;
   logic [GAP_W-1:0]      gap_q;
   logic [GAP_W-1:0]      gap_d;
   logic [3:0]            tgt_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  err_q;

   logic [3:0]            masked_tgt;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic                  can_pop;

   assign masked_tgt = req_target & ~SELF_BIT;
   assign req_ready  = !rst && (count_q < CNT_W'(QDEPTH));
   assign accept     = req_valid && req_ready;
   assign push       = accept && (masked_tgt != 4'b0000);
   assign can_pop    = (count_q != '0) && !port_full;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {masked_tgt, req_data};
      end
   end

   // State register plus queue bookkeeping and the captured head entry
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         gap_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         tgt_q    <= 4'b0000;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         err_q   <= accept && (masked_tgt == 4'b0000);
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q        <= rd_ptr_q + 1'b1;
            {tgt_q, data_q} <= mem_q[rd_ptr_q];
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (can_pop) begin
               pop     = 1'b1;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (GAP_CYCLES > 0) begin
               gap_d   = GAP_W'(GAP_CYCLES);
               state_d = S_GAP;
            end else if (can_pop) begin
               pop     = 1'b1;
               state_d = S_SEND;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GAP: begin
            gap_d = gap_q - 1'b1;
            // Last gap cycle doubles as the pop decision so spacing is GAP+1
            if (gap_q <= GAP_W'(1)) begin
               gap_d = '0;
               if (can_pop) begin
                  pop     = 1'b1;
                  state_d = S_SEND;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      tx_valid  = 1'b0;
      tx_source = 4'b0000;
      tx_target = 4'b0000;
      tx_data   = '0;
      if (state_q == S_SEND) begin
         tx_valid  = 1'b1;
         tx_source = SELF_BIT;
         tx_target = tgt_q;
         tx_data   = data_q;
      end
   end

   assign err_illegal = err_q;
   assign busy        = (state_q != S_IDLE) || (count_q != '0);

`ifdef PORT_TX_STATS_EN
   logic [15:0] sent_q;
   logic [15:0] rej_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sent_q <= 16'h0000;
         rej_q  <= 16'h0000;
      end else begin
         if ((state_q == S_SEND) && (sent_q != 16'hFFFF)) begin
            sent_q <= sent_q + 16'h0001;
         end
         if (err_q && (rej_q != 16'hFFFF)) begin
            rej_q <= rej_q + 16'h0001;
         end
      end
   end

   assign tx_sent_cnt = sent_q;
   assign tx_rej_cnt  = rej_q;
`else
   assign tx_sent_cnt = 16'h0000;
   assign tx_rej_cnt  = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_port_tx.sv
//------------------------------------------------------------------------------
// Module      : tb_switch_port_tx
// Description : Scoreboard bench for switch_port_tx; dut_a uses a one-cycle
//               gap, dut_b sends back-to-back beats.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_switch_port_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        a_req_valid, a_port_full, a_req_ready, a_tx_valid, a_err, a_busy;
   logic [3:0]  a_req_target, a_tx_source, a_tx_target;
   logic [7:0]  a_req_data, a_tx_data;
   logic [15:0] a_sent, a_rej;
   logic        b_req_valid, b_port_full, b_req_ready, b_tx_valid, b_err, b_busy;
   logic [3:0]  b_req_target, b_tx_source, b_tx_target;
   logic [7:0]  b_req_data, b_tx_data;
   logic [15:0] b_sent, b_rej;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   logic [11:0] qa[$];
   logic [11:0] qb[$];
   int a_cyc[$];
   int b_cyc[$];
   logic [11:0] ea, eb;

   switch_port_tx #(.PORT_ID(1), .DATA_WIDTH(8), .QDEPTH(4), .GAP_CYCLES(1)) dut_a (
      .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_target(a_req_target), .req_data(a_req_data), .port_full(a_port_full),
      .tx_valid(a_tx_valid), .tx_source(a_tx_source), .tx_target(a_tx_target),
      .tx_data(a_tx_data), .err_illegal(a_err), .busy(a_busy),
      .tx_sent_cnt(a_sent), .tx_rej_cnt(a_rej));

   switch_port_tx #(.PORT_ID(1), .DATA_WIDTH(8), .QDEPTH(4), .GAP_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_target(b_req_target), .req_data(b_req_data), .port_full(b_port_full),
      .tx_valid(b_tx_valid), .tx_source(b_tx_source), .tx_target(b_tx_target),
      .tx_data(b_tx_data), .err_illegal(b_err), .busy(b_busy),
      .tx_sent_cnt(b_sent), .tx_rej_cnt(b_rej));

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors: every beat pops the scoreboard; non-beat cycles must be all-zero
   always @(negedge clk) begin
      if (a_tx_valid === 1'b1) begin
         a_cyc.push_back(cyc);
         if (qa.size() == 0) begin
            tests++; fails++;
            $display("FAIL A unexpected beat: got %0h expected none", {a_tx_target, a_tx_data});
         end else begin
            ea = qa.pop_front();
            chk("A beat", {a_tx_source, a_tx_target, a_tx_data}, {4'b0010, ea});
         end
      end else begin
         chk("A idle outputs", {a_tx_source, a_tx_target, a_tx_data}, 0);
      end
   end

   always @(negedge clk) begin
      if (b_tx_valid === 1'b1) begin
         b_cyc.push_back(cyc);
         if (qb.size() == 0) begin
            tests++; fails++;
            $display("FAIL B unexpected beat: got %0h expected none", {b_tx_target, b_tx_data});
         end else begin
            eb = qb.pop_front();
            chk("B beat", {b_tx_source, b_tx_target, b_tx_data}, {4'b0010, eb});
         end
      end else begin
         chk("B idle outputs", {b_tx_source, b_tx_target, b_tx_data}, 0);
      end
   end

   // Called just after a rising edge; returns just after the accepting edge
   task automatic push(input bit sel, input logic [3:0] t, input logic [7:0] d,
                       input logic [3:0] et);
      int k = 0;
      if (!sel) begin a_req_valid = 1'b1; a_req_target = t; a_req_data = d; end
      else      begin b_req_valid = 1'b1; b_req_target = t; b_req_data = d; end
      @(negedge clk);
      while (!(sel ? b_req_ready : a_req_ready) && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!(sel ? b_req_ready : a_req_ready)) begin
         tests++; fails++;
         $display("FAIL push timeout: got ready=0 expected ready=1");
      end else if (et != 4'b0000) begin
         if (!sel) qa.push_back({et, d});
         else      qb.push_back({et, d});
      end
      @(posedge clk);
      #1;
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
   endtask

   task automatic drain(input bit sel, input string n);
      int k = 0;
      while (k < 200 && (sel ? (qb.size() != 0 || b_busy) : (qa.size() != 0 || a_busy))) begin
         @(negedge clk);
         k++;
      end
      chk(n, sel ? qb.size() : qa.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      @(negedge clk);
      chk("A ready during rst", a_req_ready, 0);
      chk("B ready during rst", b_req_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      qa.delete(); qb.delete(); a_cyc.delete(); b_cyc.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      int c0;
      rst = 1'b1;
      a_req_valid = 0; a_req_target = 0; a_req_data = 0; a_port_full = 0;
      b_req_valid = 0; b_req_target = 0; b_req_data = 0; b_port_full = 0;

      // Reset state
      do_reset();
      @(negedge clk);
      chk("reset tx_valid", a_tx_valid, 0);
      chk("reset err", a_err, 0);
      chk("reset busy", a_busy, 0);
      chk("reset B busy", b_busy, 0);
      chk("reset ready", a_req_ready, 1);
      chk("reset stats", {a_sent, a_rej}, 0);
      @(posedge clk);
      #1;

      // 1: latency C+2, then gap, then idle
      push(0, 4'b0100, 8'hA5, 4'b0100);
      @(negedge clk); chk("t1 valid C+1", a_tx_valid, 0);
      @(negedge clk); chk("t1 valid C+2", a_tx_valid, 1);
      @(negedge clk); chk("t1 valid C+3", a_tx_valid, 0);
      chk("t1 busy in gap", a_busy, 1);
      @(negedge clk); chk("t1 busy after gap", a_busy, 0);
      @(posedge clk); #1;

      // 2: self bit masking and illegal request
      do_reset();
      push(0, 4'b1111, 8'h11, 4'b1101);
      push(0, 4'b0010, 8'h22, 4'b0000);
      @(negedge clk); chk("t2 err pulse", a_err, 1);
      @(negedge clk); chk("t2 err single", a_err, 0);
      drain(0, "t2 drain");
`ifdef PORT_TX_STATS_EN
      chk("t2 sent cnt", a_sent, 1);
      chk("t2 rej cnt", a_rej, 1);
`else
      chk("t2 sent cnt", a_sent, 0);
      chk("t2 rej cnt", a_rej, 0);
`endif

      // 3: fill under port_full, then release and check order/spacing
      do_reset();
      a_port_full = 1'b1;
      for (int i = 1; i <= 4; i++) push(0, 4'b0001, 8'(i), 4'b0001);
      a_req_valid = 1'b1; a_req_target = 4'b0001; a_req_data = 8'h05;
      @(negedge clk); chk("t3 ready low when full", a_req_ready, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3 no beat while full", a_tx_valid, 0);
      end
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      a_port_full = 1'b0;
      drain(0, "t3 drain");
      chk("t3 beat count", a_cyc.size(), 4);
      for (int i = 1; i < a_cyc.size(); i++) chk("t3 spacing", a_cyc[i] - a_cyc[i-1], 2);

      // 4: back-to-back beats, then port_full raised during 2nd beat
      do_reset();
      b_port_full = 1'b1;
      for (int i = 1; i <= 3; i++) push(1, 4'b1000, 8'(i), 4'b1000);
      b_port_full = 1'b0;
      drain(1, "t4 drain a");
      chk("t4 beat count", b_cyc.size(), 3);
      for (int i = 1; i < b_cyc.size(); i++) chk("t4 spacing", b_cyc[i] - b_cyc[i-1], 1);
      b_port_full = 1'b1;
      for (int i = 4; i <= 6; i++) push(1, 4'b1000, 8'(i), 4'b1000);
      b_port_full = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      b_port_full = 1'b1;
      @(negedge clk); chk("t4 beat2 issued", b_tx_valid, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4 beat3 held", b_tx_valid, 0);
      end
      @(posedge clk); #1;
      b_port_full = 1'b0;
      @(negedge clk); chk("t4 decision cycle", b_tx_valid, 0);
      @(negedge clk); chk("t4 beat3 after release", b_tx_valid, 1);
      drain(1, "t4 drain b");

      // 5: reset during GAP with entries queued
      do_reset();
      a_port_full = 1'b1;
      for (int i = 1; i <= 3; i++) push(0, 4'b0100, 8'(8'h50 + i), 4'b0100);
      a_port_full = 1'b0;
      k = 0;
      @(negedge clk);
      while (!a_tx_valid && k < 20) begin @(negedge clk); k++; end
      chk("t5 first beat seen", a_tx_valid, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk); chk("t5 ready during rst", a_req_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      qa.delete();
      @(negedge clk);
      chk("t5 valid after rst", a_tx_valid, 0);
      chk("t5 busy after rst", a_busy, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t5 no beat after rst", a_tx_valid, 0);
      end
      @(posedge clk); #1;

      // 6: push+pop at QDEPTH-1, then pointer wrap with mixed targets
      do_reset();
      a_port_full = 1'b1;
      for (int i = 1; i <= 3; i++) push(0, 4'b0001, 8'(8'h60 + i), 4'b0001);
      a_port_full = 1'b0;
      push(0, 4'b0100, 8'h64, 4'b0100);
      c0 = cyc;
      push(0, 4'b1000, 8'h65, 4'b1000);
      chk("t6 ready held on push+pop", cyc - c0, 1);
      @(negedge clk); chk("t6 count unchanged", a_req_ready, 0);
      @(posedge clk); #1;
      drain(0, "t6 drain a");
      for (int i = 0; i < 10; i++) begin
         case (i % 4)
            0:       push(0, 4'b0001, 8'(8'h70 + i), 4'b0001);
            1:       push(0, 4'b0100, 8'(8'h70 + i), 4'b0100);
            2:       push(0, 4'b1000, 8'(8'h70 + i), 4'b1000);
            default: push(0, 4'b1111, 8'(8'h70 + i), 4'b1101);
         endcase
      end
      drain(0, "t6 drain wrap");
      chk("t6 wrap beat count", a_cyc.size(), 15);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
